// File: rtl/config_menu_engine.sv
// config_menu_engine: keypad-driven settings menu. Edits bounded fields,
// auto-repeats held keys and renders values as decimal text over valid/ready.
//
// Ports:
//   clk_in, rst_n_in          clock, async active-low reset
//   key_state_in              raw key levels (1 = pressed)
//   menu_req_in               pulse: give the keypad to the menu
//   refresh_in                pulse: re-render every field
//   wr_ready_in               text buffer accepts a write
//   wr_valid_out/addr/data    registered text-buffer write port
//   ptr_index_out             selected row
//   active_processor_out      1 = processor owns the keypad
//   fields_out                packed current field values
//   busy_out                  converting or writing
module config_menu_engine #(
  parameter int NUM_FIELDS = 13,
  parameter int FIELD_W = 8,
  parameter int DIGITS = 3,
  parameter int KEY_W = 16,
  parameter int ADDR_W = 10,
  parameter int KEY_UP = 5,
  parameter int KEY_DOWN = 8,
  parameter int KEY_DEC = 4,
  parameter int KEY_INC = 6,
  parameter int KEY_EXIT = 0,
  parameter logic [NUM_FIELDS*FIELD_W-1:0] FIELD_MIN = '0,
  parameter logic [NUM_FIELDS*FIELD_W-1:0] FIELD_MAX = '1,
  parameter logic [NUM_FIELDS*FIELD_W-1:0] FIELD_RST = '0,
  parameter logic [NUM_FIELDS*ADDR_W-1:0] FIELD_ADDR = '0,
  parameter logic [NUM_FIELDS-1:0] WRAP_MASK = '1,
  parameter logic [7:0] CHAR_BASE = 8'd0,
  parameter logic [23:0] HOLD_CYCLES = 24'd8_000_000,
  parameter logic [23:0] REPEAT_CYCLES = 24'd2_000_000,
  localparam int PTR_W =
    (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1
) (
  input  logic clk_in,
  input  logic rst_n_in,
  input  logic [KEY_W-1:0] key_state_in,
  input  logic menu_req_in,
  input  logic refresh_in,
  input  logic wr_ready_in,
  output logic wr_valid_out,
  output logic [ADDR_W-1:0] wr_addr_out,
  output logic [7:0] wr_data_out,
  output logic [PTR_W-1:0] ptr_index_out,
  output logic active_processor_out,
  output logic [NUM_FIELDS*FIELD_W-1:0] fields_out,
  output logic busy_out
);

  function automatic int dec_digits(int w);
    longint v;
    int n;
    v = (longint'(1) << w) - 1;
    n = 1;
    while (v >= 10) begin
      v = v / 10;
      n++;
    end
    return n;
  endfunction

  localparam int DD_MIN = dec_digits(FIELD_W);
  localparam int DD_N =
    (DD_MIN > DIGITS) ? DD_MIN : DIGITS;
  localparam int BCD_W = 4 * DD_N;
  localparam int CNT_W = $clog2(FIELD_W + 1);
  localparam int BEAT_W = $clog2(DIGITS + 1);
  localparam logic [PTR_W-1:0] LAST =
    PTR_W'(NUM_FIELDS - 1);

  localparam int K_UP = 0;
  localparam int K_DN = 1;
  localparam int K_EX = 2;
  localparam int K_DE = 3;
  localparam int K_IN = 4;
  localparam logic [4:0] RPT_MASK = 5'b11011;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CONVERT,
    S_WRITE
  } state_e;

  function automatic logic [BCD_W+FIELD_W-1:0] dd_step(
    input logic [BCD_W-1:0] bcd,
    input logic [FIELD_W-1:0] bin
  );
    logic [BCD_W-1:0] b;
    b = bcd;
    for (int i = 0; i < DD_N; i++) begin
      if (b[4*i +: 4] >= 4'd5)
        b[4*i +: 4] = b[4*i +: 4] + 4'd3;
    end
    return {b, bin} << 1;
  endfunction

  function automatic logic [7:0] to_char(
    input logic [BCD_W-1:0] bcd,
    input int idx
  );
    logic [3:0] d;
    d = bcd[4*idx +: 4];
    return CHAR_BASE + {4'd0, d};
  endfunction

  state_e state_q, state_d;
  logic [4:0] key_w, sync_q, prev_q;
  logic [4:0] press, held, evt;
  logic [23:0] rcnt_q, rcnt_d, thr;
  logic rph_q, rph_d, fire;
  logic [FIELD_W-1:0] fld_q [NUM_FIELDS];
  logic [FIELD_W-1:0] fld_d [NUM_FIELDS];
  logic [PTR_W-1:0] ptr_q, ptr_d, cf_q, cf_d;
  logic act_q, act_d, rfsh_q, rfsh_d;
  logic [FIELD_W-1:0] bin_q, bin_d;
  logic [BCD_W-1:0] bcd_q, bcd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic vld_q, vld_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0] data_q, data_d;
  logic [FIELD_W-1:0] cur, mn, mx, nv;
  logic wrap;
  logic [BCD_W+FIELD_W-1:0] dd;
  logic unused_keys;

  assign unused_keys = ^key_state_in;
  assign key_w = {key_state_in[KEY_INC],
                  key_state_in[KEY_DEC],
                  key_state_in[KEY_EXIT],
                  key_state_in[KEY_DOWN],
                  key_state_in[KEY_UP]};

  assign press = sync_q & ~prev_q;
  assign held = sync_q & prev_q & RPT_MASK;
  assign thr = rph_q ? REPEAT_CYCLES : HOLD_CYCLES;
  assign fire = (|held) && (rcnt_q == thr - 24'd1);
  assign evt = press | (fire ? held : 5'd0);

  always_comb begin
    state_d = state_q;
    rcnt_d = rcnt_q;
    rph_d = rph_q;
    fld_d = fld_q;
    ptr_d = ptr_q;
    cf_d = cf_q;
    act_d = act_q;
    rfsh_d = rfsh_q;
    bin_d = bin_q;
    bcd_d = bcd_q;
    cnt_d = cnt_q;
    beat_d = beat_q;
    vld_d = vld_q;
    addr_d = addr_q;
    data_d = data_q;

    cur = fld_q[ptr_q];
    mn = FIELD_MIN[int'(ptr_q)*FIELD_W +: FIELD_W];
    mx = FIELD_MAX[int'(ptr_q)*FIELD_W +: FIELD_W];
    wrap = WRAP_MASK[ptr_q];
    if (evt[K_DE])
      nv = (cur <= mn) ? (wrap ? mx : cur)
                       : cur - FIELD_W'(1);
    else
      nv = (cur >= mx) ? (wrap ? mn : cur)
                       : cur + FIELD_W'(1);
    dd = dd_step(bcd_q, bin_q);

    // One shared hold counter; restarts whenever
    // no repeatable key is held.
    if (!(|held)) begin
      rcnt_d = '0;
      rph_d = 1'b0;
    end else if (fire) begin
      rcnt_d = '0;
      rph_d = 1'b1;
    end else begin
      rcnt_d = rcnt_q + 24'd1;
    end

    unique case (state_q)
      S_IDLE: begin
        if (!act_q && evt[K_UP]) begin
          ptr_d = (ptr_q == '0) ? LAST
                                : ptr_q - PTR_W'(1);
        end else if (!act_q && evt[K_DN]) begin
          ptr_d = (ptr_q == LAST) ? '0
                                  : ptr_q + PTR_W'(1);
        end else if (!act_q && evt[K_EX]) begin
          act_d = 1'b1;
        end else if (!act_q &&
                     (evt[K_DE] || evt[K_IN])) begin
          fld_d[ptr_q] = nv;
          bin_d = nv;
          bcd_d = '0;
          cnt_d = '0;
          cf_d = ptr_q;
          rfsh_d = 1'b0;
          state_d = S_CONVERT;
        end else if (refresh_in) begin
          bin_d = fld_q[0];
          bcd_d = '0;
          cnt_d = '0;
          cf_d = '0;
          rfsh_d = 1'b1;
          state_d = S_CONVERT;
        end
      end
      S_CONVERT: begin
        bcd_d = dd[BCD_W+FIELD_W-1:FIELD_W];
        bin_d = dd[FIELD_W-1:0];
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(FIELD_W - 1)) begin
          state_d = S_WRITE;
          beat_d = '0;
          vld_d = 1'b1;
          addr_d =
            FIELD_ADDR[int'(cf_q)*ADDR_W +: ADDR_W];
          data_d = to_char(
            dd[BCD_W+FIELD_W-1:FIELD_W], DIGITS - 1);
        end
      end
      S_WRITE: begin
        if (vld_q && wr_ready_in) begin
          if (beat_q == BEAT_W'(DIGITS - 1)) begin
            vld_d = 1'b0;
            if (rfsh_q && cf_q != LAST) begin
              cf_d = cf_q + PTR_W'(1);
              bin_d = fld_q[cf_q + PTR_W'(1)];
              bcd_d = '0;
              cnt_d = '0;
              state_d = S_CONVERT;
            end else begin
              rfsh_d = 1'b0;
              state_d = S_IDLE;
            end
          end else begin
            beat_d = beat_q + BEAT_W'(1);
            addr_d = addr_q + ADDR_W'(1);
            data_d = to_char(
              bcd_q, DIGITS - 2 - int'(beat_q));
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (menu_req_in) act_d = 1'b0;
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= S_IDLE;
      sync_q <= '0;
      prev_q <= '0;
      rcnt_q <= '0;
      rph_q <= 1'b0;
      for (int i = 0; i < NUM_FIELDS; i++)
        fld_q[i] <= FIELD_RST[i*FIELD_W +: FIELD_W];
      ptr_q <= '0;
      cf_q <= '0;
      act_q <= 1'b1;
      rfsh_q <= 1'b0;
      bin_q <= '0;
      bcd_q <= '0;
      cnt_q <= '0;
      beat_q <= '0;
      vld_q <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      state_q <= state_d;
      sync_q <= key_w;
      prev_q <= sync_q;
      rcnt_q <= rcnt_d;
      rph_q <= rph_d;
      fld_q <= fld_d;
      ptr_q <= ptr_d;
      cf_q <= cf_d;
      act_q <= act_d;
      rfsh_q <= rfsh_d;
      bin_q <= bin_d;
      bcd_q <= bcd_d;
      cnt_q <= cnt_d;
      beat_q <= beat_d;
      vld_q <= vld_d;
      addr_q <= addr_d;
      data_q <= data_d;
    end
  end

  assign wr_valid_out = vld_q;
  assign wr_addr_out = addr_q;
  assign wr_data_out = data_q;
  assign ptr_index_out = ptr_q;
  assign active_processor_out = act_q;
  assign busy_out = (state_q != S_IDLE);

  for (genvar g = 0; g < NUM_FIELDS; g++) begin : g_fo
    assign fields_out[g*FIELD_W +: FIELD_W] = fld_q[g];
  end

endmodule

// File: tb/tb_config_menu_engine.sv
// Scoreboard bench for config_menu_engine: expected writes are queued
// by the stimulus and popped by a write-port monitor.
module tb_config_menu_engine;

  localparam int N = 13;
  localparam int FW = 8;
  localparam int AW = 10;
  localparam int PW = 4;
  localparam int K_UP = 5;
  localparam int K_DOWN = 8;
  localparam int K_DEC = 4;
  localparam int K_INC = 6;
  localparam int K_EXIT = 0;
  localparam logic [7:0] CB = 8'h30;

  function automatic int rst_val(int i);
    case (i)
      0: return 255;
      1: return 8;
      4: return 9;
      5: return 10;
      6: return 99;
      7: return 100;
      8: return 128;
      9: return 200;
      10: return 7;
      11: return 55;
      12: return 254;
      default: return 0;
    endcase
  endfunction

  function automatic int min_val(int i);
    return (i == 1) ? 1 : 0;
  endfunction

  function automatic int max_val(int i);
    return (i == 1) ? 8 : 255;
  endfunction

  function automatic int addr_val(int i);
    return i * 32 + 5;
  endfunction

  function automatic logic [N*FW-1:0] mk_min();
    logic [N*FW-1:0] v;
    for (int i = 0; i < N; i++)
      v[i*FW +: FW] = FW'(min_val(i));
    return v;
  endfunction

  function automatic logic [N*FW-1:0] mk_max();
    logic [N*FW-1:0] v;
    for (int i = 0; i < N; i++)
      v[i*FW +: FW] = FW'(max_val(i));
    return v;
  endfunction

  function automatic logic [N*FW-1:0] mk_rst();
    logic [N*FW-1:0] v;
    for (int i = 0; i < N; i++)
      v[i*FW +: FW] = FW'(rst_val(i));
    return v;
  endfunction

  function automatic logic [N*AW-1:0] mk_addr();
    logic [N*AW-1:0] v;
    for (int i = 0; i < N; i++)
      v[i*AW +: AW] = AW'(addr_val(i));
    return v;
  endfunction

  localparam logic [N*FW-1:0] P_MIN = mk_min();
  localparam logic [N*FW-1:0] P_MAX = mk_max();
  localparam logic [N*FW-1:0] P_RST = mk_rst();
  localparam logic [N*AW-1:0] P_ADDR = mk_addr();
  localparam logic [N-1:0] P_WRAP = 13'h1FFB;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [15:0] key = '0;
  logic menu_req = 1'b0;
  logic refresh = 1'b0;
  logic rdy = 1'b1;
  logic wr_valid;
  logic [AW-1:0] wr_addr;
  logic [7:0] wr_data;
  logic [PW-1:0] ptr;
  logic active;
  logic [N*FW-1:0] fields;
  logic busy;

  always #5 clk = ~clk;

  config_menu_engine #(
    .NUM_FIELDS(N), .FIELD_W(FW), .DIGITS(3),
    .KEY_W(16), .ADDR_W(AW),
    .KEY_UP(K_UP), .KEY_DOWN(K_DOWN),
    .KEY_DEC(K_DEC), .KEY_INC(K_INC),
    .KEY_EXIT(K_EXIT),
    .FIELD_MIN(P_MIN), .FIELD_MAX(P_MAX),
    .FIELD_RST(P_RST), .FIELD_ADDR(P_ADDR),
    .WRAP_MASK(P_WRAP), .CHAR_BASE(CB),
    .HOLD_CYCLES(24'd40), .REPEAT_CYCLES(24'd20)
  ) dut (
    .clk_in(clk),
    .rst_n_in(rst_n),
    .key_state_in(key),
    .menu_req_in(menu_req),
    .refresh_in(refresh),
    .wr_ready_in(rdy),
    .wr_valid_out(wr_valid),
    .wr_addr_out(wr_addr),
    .wr_data_out(wr_data),
    .ptr_index_out(ptr),
    .active_processor_out(active),
    .fields_out(fields),
    .busy_out(busy)
  );

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [7:0] data;
  } wr_t;

  wr_t exp_q[$];
  int checks = 0;
  int errors = 0;
  int beats = 0;
  int mdl [N];

  task automatic chk(input string nm,
                     input logic [127:0] got,
                     input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               nm, got, exp);
    end
  endtask

  function automatic logic [N*FW-1:0] mdl_packed();
    logic [N*FW-1:0] v;
    for (int i = 0; i < N; i++)
      v[i*FW +: FW] = FW'(mdl[i]);
    return v;
  endfunction

  task automatic push_field(input int i);
    wr_t w;
    int v;
    int d;
    v = mdl[i];
    for (int k = 0; k < 3; k++) begin
      d = (k == 0) ? (v / 100) % 10 :
          (k == 1) ? (v / 10) % 10 : v % 10;
      w.addr = AW'(addr_val(i) + k);
      w.data = CB + 8'(d);
      exp_q.push_back(w);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && wr_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: addr %0d data %0h",
                 wr_addr, wr_data);
      end else begin
        if (wr_addr !== exp_q[0].addr ||
            wr_data !== exp_q[0].data) begin
          errors++;
          $display("FAIL write_beat: got %0d/%0h expected %0d/%0h",
                   wr_addr, wr_data,
                   exp_q[0].addr, exp_q[0].data);
        end
        if (rdy) begin
          void'(exp_q.pop_front());
          beats++;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press_key(input int k, input int n);
    key[k] = 1'b1;
    repeat (n) tick();
    key[k] = 1'b0;
    tick();
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    while ((busy || exp_q.size() != 0) && n < 1000) begin
      tick();
      n++;
    end
    chk(nm, 128'(exp_q.size()), 128'd0);
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int b0;
    for (int i = 0; i < N; i++) mdl[i] = rst_val(i);
    repeat (3) tick();
    chk("rst_valid", wr_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ptr", ptr, 0);
    chk("rst_active", active, 1'b1);
    chk("rst_addr", wr_addr, 0);
    chk("rst_data", wr_data, 0);
    chk("rst_fields", fields, P_RST);
    rst_n = 1'b1;
    tick();

    press_key(K_DOWN, 1);
    chk("inactive_ignore", ptr, 0);
    menu_req = 1'b1;
    tick();
    menu_req = 1'b0;
    chk("menu_req", active, 1'b0);

    repeat (14) press_key(K_DOWN, 1);
    chk("down_wrap", ptr, 1);
    chk("no_writes", beats, 0);

    mdl[1] = 1;
    push_field(1);
    press_key(K_INC, 1);
    chk("inc_wrap_busy", busy, 1'b1);
    chk("inc_wrap_val", fields[1*FW +: FW], 1);
    n = 0;
    while (!wr_valid && n < 50) begin
      tick();
      n++;
    end
    chk("convert_cycles", n, 8);
    wait_idle("inc_drain");
    chk("fields_a", fields, mdl_packed());

    press_key(K_DOWN, 1);
    chk("ptr2", ptr, 2);
    push_field(2);
    press_key(K_DEC, 1);
    wait_idle("sat_drain");
    chk("sat_hold", fields[2*FW +: FW], 0);

    rdy = 1'b0;
    mdl[2] = 1;
    push_field(2);
    press_key(K_INC, 1);
    n = 0;
    while (!wr_valid && n < 50) begin
      tick();
      n++;
    end
    repeat (5) begin
      tick();
      chk("stall_busy", busy, 1'b1);
      chk("stall_addr", wr_addr, addr_val(2));
      chk("stall_data", wr_data, CB);
    end
    rdy = 1'b1;
    tick();
    chk("stall_release", wr_addr, addr_val(2) + 1);
    wait_idle("stall_drain");

    press_key(K_DOWN, 1);
    for (int v = 1; v <= 3; v++) begin
      mdl[3] = v;
      push_field(3);
    end
    press_key(K_INC, 80);
    wait_idle("repeat_drain");
    chk("repeat_count", fields[3*FW +: FW], 3);
    mdl[3] = 4;
    push_field(3);
    press_key(K_INC, 1);
    press_key(K_INC, 1);
    wait_idle("busy_drain");
    chk("busy_lost", fields[3*FW +: FW], 4);

    repeat (4) press_key(K_UP, 1);
    chk("up_wrap", ptr, 12);
    press_key(K_EXIT, 1);
    chk("exit", active, 1'b1);
    press_key(K_DOWN, 1);
    chk("exit_ignore", ptr, 12);
    chk("fields_b", fields, mdl_packed());

    b0 = beats;
    for (int i = 0; i < N; i++) push_field(i);
    refresh = 1'b1;
    tick();
    refresh = 1'b0;
    wait_idle("refresh_drain");
    chk("refresh_beats", beats - b0, 3 * N);

    b0 = beats;
    for (int i = 0; i < N; i++) push_field(i);
    refresh = 1'b1;
    tick();
    refresh = 1'b0;
    n = 0;
    while (beats < b0 + 4 && n < 500) begin
      tick();
      n++;
    end
    chk("abort_point", beats - b0, 4);
    rst_n = 1'b0;
    #1;
    chk("abort_valid", wr_valid, 1'b0);
    chk("abort_busy", busy, 1'b0);
    chk("abort_fields", fields, P_RST);
    chk("abort_ptr", ptr, 0);
    chk("abort_active", active, 1'b1);
    exp_q.delete();
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (10) tick();
    chk("abort_no_beats", beats - b0, 4);
    chk("abort_idle", busy, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
